// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single-port, 1-cycle-latency SRAM; registers the command
// and returns read data to the issuing port. Define SRAM_ARB_RR_EN for round-robin arbitration.
module sram_arbiter #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  p0_req,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);

  typedef struct packed {
    logic valid;
    logic port;
    logic is_read;
  } tag_t;

  logic                  sram_en_q, sram_we_q;
  logic [ADDR_WIDTH-1:0] sram_addr_q;
  logic [DATA_WIDTH-1:0] sram_wdata_q;
  tag_t                  tag0_q, tag1_q, tag_d;
  logic                  p0_rvalid_q, p1_rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  accept;

`ifdef SRAM_ARB_RR_EN
  logic rr_q;  // preferred port on simultaneous requests

  always_comb begin
    p0_gnt = p0_req;
    p1_gnt = p1_req;
    if (p0_req && p1_req) begin
      p0_gnt = ~rr_q;
      p1_gnt = rr_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_q <= 1'b0;
    end else if (accept) begin
      rr_q <= p0_gnt;
    end
  end
`else
  always_comb begin
    p0_gnt = p0_req;
    p1_gnt = p1_req & ~p0_req;
  end
`endif

  assign accept = p0_gnt | p1_gnt;

  always_comb begin
    tag_d         = '0;
    tag_d.valid   = accept;
    tag_d.port    = p1_gnt;
    tag_d.is_read = p0_gnt | (p1_gnt & ~p1_we);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sram_en_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
    end else begin
      sram_en_q <= accept;
      sram_we_q <= p1_gnt & p1_we;
      if (p0_gnt) begin
        sram_addr_q <= p0_addr;
      end else if (p1_gnt) begin
        sram_addr_q  <= p1_addr;
        sram_wdata_q <= p1_wdata;
      end
    end
  end

  // tag0 tracks the command on the SRAM pins, tag1 the one whose data is on sram_rdata
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag0_q      <= '0;
      tag1_q      <= '0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      tag0_q      <= tag_d;
      tag1_q      <= tag0_q;
      p0_rvalid_q <= tag1_q.valid & tag1_q.is_read & ~tag1_q.port;
      p1_rvalid_q <= tag1_q.valid & tag1_q.is_read & tag1_q.port;
      rdata_q     <= sram_rdata;
    end
  end

  assign sram_en    = sram_en_q;
  assign sram_we    = sram_we_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;
  assign p0_rvalid  = p0_rvalid_q;
  assign p1_rvalid  = p1_rvalid_q;
  assign p0_rdata   = rdata_q;
  assign p1_rdata   = rdata_q;

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-requester arbiter that shares one single-port, 1-cycle-read-latency block SRAM (`sram`).
- Port 0 is the display pixel fetcher, latency-critical. Port 1 is the game/sprite engine, which does reads and writes.
- Sits between the requesters and the SRAM instance. Registers the chosen command onto the SRAM pins and routes read data back to the port that issued it.

Parameters:
- ADDR_WIDTH, 16, address width; matches SRAM addr.
- DATA_WIDTH, 8, data width; matches SRAM data_i/data_o.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- p0_req  in  1  port 0 request; held with p0_addr until p0_gnt.
- p0_addr  in  ADDR_WIDTH  port 0 read address.
- p0_gnt  out  1  port 0 request accepted this cycle.
- p0_rvalid  out  1  p0_rdata valid (single-cycle pulse).
- p0_rdata  out  DATA_WIDTH  port 0 read data.
- p1_req  in  1  port 1 request; held with p1_we/p1_addr/p1_wdata until p1_gnt.
- p1_we  in  1  1 = write, 0 = read.
- p1_addr  in  ADDR_WIDTH  port 1 address.
- p1_wdata  in  DATA_WIDTH  port 1 write data.
- p1_gnt  out  1  port 1 request accepted this cycle.
- p1_rvalid  out  1  p1_rdata valid (single-cycle pulse, reads only).
- p1_rdata  out  DATA_WIDTH  port 1 read data.
- sram_en  out  1  SRAM enable (registered).
- sram_we  out  1  SRAM write enable (registered).
- sram_addr  out  ADDR_WIDTH  SRAM address (registered).
- sram_wdata  out  DATA_WIDTH  SRAM write data (registered).
- sram_rdata  in  DATA_WIDTH  SRAM data_o.

Behaviour:
- Reset (asynchronous, reset_n=0) forces:
  - sram_en, sram_we, sram_addr, sram_wdata to 0.
  - both rvalid to 0, both in-flight tags cleared, RR pointer to port 0.
- Reads in flight when reset asserts are discarded; no rvalid appears after reset release.
- Grant is combinational from req and arbitration state; at most one of p0_gnt/p1_gnt is high per cycle.
- Handshake: a request is accepted on the rising edge where req && gnt.
- Requesters must hold req and payload stable until gnt. Dropping req before gnt withdraws the request with no side effects.
- Back-to-back acceptance is allowed every cycle, so throughput is 1 access per cycle.
- Fixed priority (default): p0 wins whenever p0_req=1; p1 is granted only when p0_req=0.
- Command stage, at the acceptance edge T:
  - sram_en=1.
  - sram_we = p1_we for port 1, 0 for port 0.
  - sram_addr and sram_wdata are loaded from the winner.
  - A 2-entry tag shift pipeline records {valid, port, is_read}.
- Cycle with no acceptance: sram_en=0, sram_we=0; sram_addr and sram_wdata hold their previous values.
- Read latency: accepted at edge T → SRAM samples at edge T+1 → rvalid high for the cycle following edge T+2.
  - rdata = sram_rdata, steered by the tag.
  - Exactly 2 cycles from acceptance to rvalid, fixed.
- Writes produce no rvalid. The SRAM returns write data on data_o during a write; this is ignored.
- rdata of the non-valid port is don't-care; the implementation drives sram_rdata to both ports.
- Read-after-write to the same address, accepted on consecutive cycles, returns the new data (SRAM ordering). The arbiter adds no forwarding.
- Both requests idle: nothing is issued; the tag pipeline drains normally.

Optional Feature:
- Macro SRAM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit pointer names the preferred port; on simultaneous requests the preferred port wins.
  - After each acceptance the pointer moves to the other port.
  - A single requester is still granted every cycle.
  - The pointer resets to port 0.
- Undefined: fixed priority with p0 highest. Port 1 may starve while p0_req is held continuously.

Test Plan:
- Reset: hold reset_n=0 with both reqs high → sram_en=0, sram_we=0, sram_addr=0, no gnt effects latched. Release → first grant next cycle.
- P0 read: preload mem[0x0010]=0xA5; p0_req with addr 0x0010 → p0_gnt same cycle; sram_en=1/addr=0x0010 next cycle; p0_rvalid=1 with p0_rdata=0xA5 exactly 2 cycles after acceptance; p1_rvalid stays 0.
- P1 write then read: p1 write 0x3C to 0x0200, then read 0x0200 on the next cycle → sram_we=1 for one cycle; p1_rvalid once with 0x3C; no rvalid for the write.
- Contention, fixed priority: both req every cycle for 4 cycles → p0_gnt all 4 cycles, p1_gnt 0. Drop p0_req → p1_gnt the next cycle.
- Contention, SRAM_ARB_RR_EN defined: both req for 4 cycles → grants alternate p0,p1,p0,p1. Each rvalid returns the data of its own address (p0 addr 0x0001=0x11, p1 addr 0x0002=0x22).
- Reset mid-read: accept a p0 read, assert reset_n=0 at the next edge, release → no p0_rvalid/p1_rvalid ever pulses for that read.
